// File: rtl/ysyx_220053_if_id_buf.sv
// IF/ID pipeline boundary: two-entry skid buffer between fetch and decode.
// in_ready comes straight from the skid valid register, so decode never reaches fetch combinationally.
module ysyx_220053_if_id_buf #(
    parameter int                 PC_W    = 64,
    parameter int                 INSTR_W = 32,
    parameter logic [INSTR_W-1:0] BUBBLE  = 32'h00000013
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    input  logic               flush,
    output logic [31:0]        stall_cnt
);

    logic               main_valid_q, main_valid_d;
    logic [PC_W-1:0]    main_pc_q, main_pc_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic               skid_valid_q, skid_valid_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [31:0]        stall_cnt_q, stall_cnt_d;

    logic in_fire;
    logic out_fire;

    assign in_ready  = ~skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_pc    = main_valid_q ? main_pc_q : '0;
    assign out_instr = main_valid_q ? main_instr_q : BUBBLE;
    assign stall_cnt = stall_cnt_q;

    assign in_fire  = in_valid & ~skid_valid_q;
    assign out_fire = main_valid_q & out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_pc_d    = main_pc_q;
        main_instr_d = main_instr_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;

        if (flush) begin
            // Redirect squashes everything, including a pair offered this cycle.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q) begin
            if (in_fire) begin
                main_valid_d = 1'b1;
                main_pc_d    = in_pc;
                main_instr_d = in_instr;
            end
        end else if (!skid_valid_q) begin
            if (in_fire && out_fire) begin
                main_pc_d    = in_pc;
                main_instr_d = in_instr;
            end else if (in_fire) begin
                skid_valid_d = 1'b1;
                skid_pc_d    = in_pc;
                skid_instr_d = in_instr;
            end else if (out_fire) begin
                main_valid_d = 1'b0;
            end
        end else if (out_fire) begin
            main_pc_d    = skid_pc_q;
            main_instr_d = skid_instr_q;
            skid_valid_d = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_valid_q && !out_ready) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_pc_q    <= '0;
            main_instr_q <= BUBBLE;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= BUBBLE;
            stall_cnt_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_pc_q    <= main_pc_d;
            main_instr_q <= main_instr_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_ysyx_220053_if_id_buf.sv
// Directed checks of the IF/ID skid buffer: reset, streaming, back-pressure, flush, async reset.
module tb_ysyx_220053_if_id_buf;

    localparam logic [31:0] BUBBLE = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        flush;
    logic [31:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    ysyx_220053_if_id_buf dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .flush     (flush),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            $display("check %s ok: observed=%h", tag, obs);
        end else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_in_ready"},  {63'd0, in_ready},  64'd1);
        chk({tag, "_out_pc"},    out_pc,             64'd0);
        chk({tag, "_out_instr"}, {32'd0, out_instr}, {32'd0, BUBBLE});
    endtask

    task automatic chk_head(input string tag, input logic [63:0] pc, input logic [31:0] instr);
        chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd1);
        chk({tag, "_out_pc"},    out_pc,             pc);
        chk({tag, "_out_instr"}, {32'd0, out_instr}, {32'd0, instr});
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 64'hDEAD_BEEF_0000_0000;
        in_instr  = 32'hFFFF_FFFF;
        out_ready = 1'b0;
        flush     = 1'b0;

        // Reset held with live inputs
        #2;
        chk_empty("reset");
        chk("reset_stall", {32'd0, stall_cnt}, 64'd0);
        tick();
        chk_empty("reset_edge");
        chk("reset_edge_stall", {32'd0, stall_cnt}, 64'd0);
        rst      = 1'b0;
        in_valid = 1'b0;

        // Streaming at full rate
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_pc    = 64'h8000_0000 + 64'(4 * k);
            in_instr = 32'h0010_0093 + 32'(k);
            chk($sformatf("stream%0d_in_ready", k), {63'd0, in_ready}, 64'd1);
            tick();
            chk_head($sformatf("stream%0d", k), 64'h8000_0000 + 64'(4 * k), 32'h0010_0093 + 32'(k));
        end
        in_valid = 1'b0;
        tick();
        chk_empty("stream_end");
        chk("stream_stall", {32'd0, stall_cnt}, 64'd0);

        // Back-pressure fill
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 64'h8000_0000;
        in_instr  = 32'h0000_0011;
        tick();
        chk_head("fill_a", 64'h8000_0000, 32'h0000_0011);
        chk("fill_a_in_ready", {63'd0, in_ready}, 64'd1);
        chk("fill_a_stall", {32'd0, stall_cnt}, 64'd0);
        in_pc    = 64'h8000_0004;
        in_instr = 32'h0000_0022;
        tick();
        chk_head("fill_b", 64'h8000_0000, 32'h0000_0011);
        chk("fill_b_in_ready", {63'd0, in_ready}, 64'd0);
        chk("fill_b_stall", {32'd0, stall_cnt}, 64'd1);
        in_pc    = 64'h8000_0008;
        in_instr = 32'h0000_0033;
        tick();
        chk_head("fill_c_held", 64'h8000_0000, 32'h0000_0011);
        chk("fill_c_in_ready", {63'd0, in_ready}, 64'd0);
        chk("fill_c_stall", {32'd0, stall_cnt}, 64'd2);
        tick();
        chk("fill_c2_stall", {32'd0, stall_cnt}, 64'd3);

        // Back-pressure drain, C still offered
        out_ready = 1'b1;
        tick();
        chk_head("drain_b", 64'h8000_0004, 32'h0000_0022);
        chk("drain_b_in_ready", {63'd0, in_ready}, 64'd1);
        chk("drain_b_stall", {32'd0, stall_cnt}, 64'd3);
        tick();
        chk_head("drain_c", 64'h8000_0008, 32'h0000_0033);
        in_valid = 1'b0;
        tick();
        chk_empty("drain_end");

        // Flush while FULL with a pair offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 64'h9000_0000;
        in_instr  = 32'h0000_0044;
        tick();
        in_pc    = 64'h9000_0004;
        in_instr = 32'h0000_0055;
        tick();
        chk_head("flush_full", 64'h9000_0000, 32'h0000_0044);
        chk("flush_full_in_ready", {63'd0, in_ready}, 64'd0);
        chk("flush_full_stall", {32'd0, stall_cnt}, 64'd4);
        flush    = 1'b1;
        in_pc    = 64'h9000_0008;
        in_instr = 32'h0000_0066;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk_empty("flush_next");
        chk("flush_stall", {32'd0, stall_cnt}, 64'd5);
        tick();
        chk_empty("flush_after");

        // Asynchronous reset while FULL
        in_valid = 1'b1;
        in_pc    = 64'hA000_0000;
        in_instr = 32'h0000_0077;
        tick();
        in_pc    = 64'hA000_0004;
        in_instr = 32'h0000_0088;
        tick();
        chk("areset_pre_in_ready", {63'd0, in_ready}, 64'd0);
        chk("areset_pre_stall", {32'd0, stall_cnt}, 64'd6);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_empty("areset");
        chk("areset_stall", {32'd0, stall_cnt}, 64'd0);
        #1;
        rst = 1'b0;
        tick();
        chk_empty("areset_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
